// File: rtl/condicionador_botoes_if.sv
// Button conditioner signal bundle: raw active-low pins in, debounced level and
// one-cycle press/release pulses out.
interface condicionador_botoes_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] key_n_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press_pulse;
  logic [NUM_KEYS-1:0] key_release_pulse;

  modport master (
    output key_n_in,
    input  key_level,
    input  key_press_pulse,
    input  key_release_pulse
  );

  modport slave (
    input  key_n_in,
    output key_level,
    output key_press_pulse,
    output key_release_pulse
  );
endinterface

// File: rtl/condicionador_botoes.sv
// Button conditioner: per-channel 2-flop synchronizer, independent 4-state
// debounce FSM with its own counter, and registered level/press/release outputs.
module condicionador_botoes #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                   CLOCK_50,
  input logic                   KEY_RESET,
  condicionador_botoes_if.slave keys
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_UM     = CNT_W'(1);

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTA = 2'd3
  } estado_t;

  logic [NUM_KEYS-1:0] sync_a;
  logic [NUM_KEYS-1:0] sync_b;
  logic [NUM_KEYS-1:0] amostra;
  logic [NUM_KEYS-1:0] nivel_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] solta_vec;

  // Synchronizer resets to "released" so a button held through reset is seen as a new press.
  always_ff @(posedge CLOCK_50 or negedge KEY_RESET) begin
    if (!KEY_RESET) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= keys.key_n_in;
      sync_b <= sync_a;
    end
  end

  assign amostra = ~sync_b;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_canal
    estado_t          estado;
    estado_t          prox_estado;
    logic [CNT_W-1:0] contador;
    logic [CNT_W-1:0] prox_contador;
    logic             prox_nivel;
    logic             prox_press;
    logic             prox_solta;
    logic             nivel_q;
    logic             press_q;
    logic             solta_q;

    always_ff @(posedge CLOCK_50 or negedge KEY_RESET) begin
      if (!KEY_RESET) begin
        estado   <= SOLTO;
        contador <= '0;
      end else begin
        estado   <= prox_estado;
        contador <= prox_contador;
      end
    end

    // A CONFIRMA state either falls back on any sample of the old level or commits once the counter reaches its last value.
    always_comb begin
      prox_estado   = estado;
      prox_contador = contador;
      case (estado)
        SOLTO: begin
          if (amostra[i]) begin
            prox_estado   = CONFIRMA_PRESS;
            prox_contador = CNT_UM;
          end
        end
        CONFIRMA_PRESS: begin
          if (!amostra[i]) begin
            prox_estado   = SOLTO;
            prox_contador = '0;
          end else if (contador == CNT_ULTIMO) begin
            prox_estado   = PRESSIONADO;
            prox_contador = '0;
          end else begin
            prox_contador = contador + 1'b1;
          end
        end
        PRESSIONADO: begin
          if (!amostra[i]) begin
            prox_estado   = CONFIRMA_SOLTA;
            prox_contador = CNT_UM;
          end
        end
        CONFIRMA_SOLTA: begin
          if (amostra[i]) begin
            prox_estado   = PRESSIONADO;
            prox_contador = '0;
          end else if (contador == CNT_ULTIMO) begin
            prox_estado   = SOLTO;
            prox_contador = '0;
          end else begin
            prox_contador = contador + 1'b1;
          end
        end
        default: begin
          prox_estado   = SOLTO;
          prox_contador = '0;
        end
      endcase
    end

    always_comb begin
      prox_press = (estado == CONFIRMA_PRESS) && (prox_estado == PRESSIONADO);
      prox_solta = (estado == CONFIRMA_SOLTA) && (prox_estado == SOLTO);
      prox_nivel = (prox_estado == PRESSIONADO) || (prox_estado == CONFIRMA_SOLTA);
    end

    always_ff @(posedge CLOCK_50 or negedge KEY_RESET) begin
      if (!KEY_RESET) begin
        nivel_q <= 1'b0;
        press_q <= 1'b0;
        solta_q <= 1'b0;
      end else begin
        nivel_q <= prox_nivel;
        press_q <= prox_press;
        solta_q <= prox_solta;
      end
    end

    assign nivel_vec[i] = nivel_q;
    assign press_vec[i] = press_q;
    assign solta_vec[i] = solta_q;
  end

  assign keys.key_level         = nivel_vec;
  assign keys.key_press_pulse   = press_vec;
  assign keys.key_release_pulse = solta_vec;

endmodule
